// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage of the pipelined MIPS core. Owns the
//             fetch PC, presents the word address to the combinational
//             instruction memory and captures the fetched word into the
//             IF/ID pipeline register. Supports stall, flush and redirect
//             with MIPS delay-slot semantics (a redirect never kills the
//             instruction already in F).
//  Ports    : clk          - system clock, rising-edge
//             reset        - asynchronous, active-low reset
//             stall        - hold PC and IF/ID
//             flush        - turn IF/ID into a bubble (overrides stall)
//             redirect     - load redirect_pc into the PC (ignored on stall)
//             redirect_pc  - redirect target
//             im_addr      - word address to instruction memory
//             im_instr     - instruction word from instruction memory
//             pc_f         - current fetch PC
//             instr_d      - IF/ID instruction
//             pc_d         - IF/ID PC
//             pc8_d        - pc_d + 8 (link value for jal/jalr)
//             valid_d      - IF/ID holds a real fetched instruction
//             addr_err_d   - IF/ID instruction came from a bad fetch address
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    output logic [IM_AW-1:0] im_addr,
    input  logic [31:0]      im_instr,
    output logic [31:0]      pc_f,
    output logic [31:0]      instr_d,
    output logic [31:0]      pc_d,
    output logic [31:0]      pc8_d,
    output logic             valid_d,
    output logic             addr_err_d
);

    localparam logic [31:0] c_pc_step   = 32'd4;
    localparam logic [31:0] c_link_step = 32'd8;

    logic [31:0] r_pc_f;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic        r_valid_d;
    logic        r_addr_err_d;

    logic [31:0] w_offset;
    logic        w_misaligned;
    logic        w_below_base;
    logic        w_above_top;
    logic        w_fetch_err;

    // Byte offset of the fetch PC inside the instruction memory window.
    // When pc_f >= IM_BASE this subtraction cannot wrap, so any set bit
    // above the word-address field means the PC is past the last word.
    assign w_offset     = r_pc_f - IM_BASE;
    assign im_addr      = w_offset[IM_AW+1:2];

    // pc_f[1:0] recovered from the offset so the whole difference feeds the
    // error logic; this holds for any IM_BASE alignment.
    assign w_misaligned = |(w_offset[1:0] + IM_BASE[1:0]);
    assign w_below_base = (r_pc_f < IM_BASE);
    assign w_above_top  = |w_offset[31:IM_AW+2];
    assign w_fetch_err  = w_misaligned | w_below_base | w_above_top;

    // Fetch PC: stall wins over redirect because the D stage is frozen too
    // and will re-present the redirect once the stall drops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc_f <= PC_RESET;
        end else if (!stall) begin
            if (redirect) begin
                r_pc_f <= redirect_pc;
            end else begin
                r_pc_f <= r_pc_f + c_pc_step;
            end
        end
    end

    // IF/ID register. Flush overrides stall; a bad fetch still advances as a
    // valid slot carrying a nop so the exception can be raised downstream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr_d    <= 32'd0;
            r_pc_d       <= PC_RESET;
            r_valid_d    <= 1'b0;
            r_addr_err_d <= 1'b0;
        end else if (flush) begin
            r_instr_d    <= 32'd0;
            r_pc_d       <= r_pc_f;
            r_valid_d    <= 1'b0;
            r_addr_err_d <= 1'b0;
        end else if (!stall) begin
            r_instr_d    <= w_fetch_err ? 32'd0 : im_instr;
            r_pc_d       <= r_pc_f;
            r_valid_d    <= 1'b1;
            r_addr_err_d <= w_fetch_err;
        end
    end

    assign pc_f       = r_pc_f;
    assign instr_d    = r_instr_d;
    assign pc_d       = r_pc_d;
    assign pc8_d      = r_pc_d + c_link_step;
    assign valid_d    = r_valid_d;
    assign addr_err_d = r_addr_err_d;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage. Directed steps for reset,
//             sequential fetch, stall, delay slot, flush and fetch errors,
//             followed by randomized stall/flush/redirect traffic compared
//             against a behavioural pipeline model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_pc_reset = 32'h0000_3000;
    localparam logic [31:0] c_im_base  = 32'h0000_3000;
    localparam int          c_im_aw    = 12;
    localparam int          c_im_words = 4096;

    logic              clk;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [c_im_aw-1:0] im_addr;
    logic [31:0]       im_instr;
    logic [31:0]       pc_f;
    logic [31:0]       instr_d;
    logic [31:0]       pc_d;
    logic [31:0]       pc8_d;
    logic              valid_d;
    logic              addr_err_d;

    logic [31:0] mem [0:c_im_words-1];

    int errors = 0;
    int checks = 0;

    // Behavioural model state: architectural fetch PC and IF/ID contents.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_valid;
    logic        m_err;

    if_stage #(
        .PC_RESET (c_pc_reset),
        .IM_BASE  (c_im_base),
        .IM_AW    (c_im_aw)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .im_addr     (im_addr),
        .im_instr    (im_instr),
        .pc_f        (pc_f),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc8_d       (pc8_d),
        .valid_d     (valid_d),
        .addr_err_d  (addr_err_d)
    );

    assign im_instr = mem[im_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit bad_addr(input logic [31:0] pc);
        longint unsigned p;
        longint unsigned lo;
        longint unsigned hi;
        p  = longint'(pc);
        lo = longint'(c_im_base);
        hi = lo + 4 * c_im_words;
        return (p % 4 != 0) || (p < lo) || (p >= hi);
    endfunction

    function automatic int word_index(input logic [31:0] pc);
        logic [31:0] off;
        off = pc - c_im_base;
        return int'((off / 4) % c_im_words);
    endfunction

    task automatic model_reset();
        m_pc    = c_pc_reset;
        m_instr = 32'd0;
        m_pcd   = c_pc_reset;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    // One clock edge of the pipeline as described behaviourally.
    task automatic model_edge(input bit st, input bit fl, input bit rd, input logic [31:0] rpc);
        logic [31:0] cur;
        cur = m_pc;
        if (fl) begin
            m_instr = 32'd0; m_pcd = cur; m_valid = 1'b0; m_err = 1'b0;
        end else if (!st) begin
            m_pcd   = cur;
            m_valid = 1'b1;
            m_err   = bad_addr(cur);
            m_instr = m_err ? 32'd0 : mem[word_index(cur)];
        end
        if (!st) m_pc = rd ? rpc : cur + 32'd4;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":pc_f"},       pc_f,                 m_pc);
        chk({where, ":im_addr"},    32'(im_addr),         32'(word_index(m_pc)));
        chk({where, ":instr_d"},    instr_d,              m_instr);
        chk({where, ":pc_d"},       pc_d,                 m_pcd);
        chk({where, ":pc8_d"},      pc8_d,                m_pcd + 32'd8);
        chk({where, ":valid_d"},    32'(valid_d),         32'(m_valid));
        chk({where, ":addr_err_d"}, 32'(addr_err_d),      32'(m_err));
    endtask

    task automatic check_reset_values(input string where);
        chk({where, ":pc_f"},    pc_f,         32'h0000_3000);
        chk({where, ":valid_d"}, 32'(valid_d), 32'd0);
        chk({where, ":instr_d"}, instr_d,      32'd0);
        chk({where, ":pc_d"},    pc_d,         32'h0000_3000);
        chk({where, ":pc8_d"},   pc8_d,        32'h0000_3008);
        chk({where, ":err"},     32'(addr_err_d), 32'd0);
    endtask

    // Drive inputs, advance one edge in both DUT and model, then compare.
    task automatic step(input string where, input bit st, input bit fl, input bit rd,
                        input logic [31:0] rpc);
        stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
        model_edge(st, fl, rd, rpc);
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    initial begin
        for (int i = 0; i < c_im_words; i++) mem[i] = $urandom;
        mem[0] = 32'h3C01_0001;
        mem[1] = 32'h3421_0002;
        mem[2] = 32'h0000_0000;

        stall = 0; flush = 0; redirect = 0; redirect_pc = 32'd0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset_hold");

        @(negedge clk);
        reset = 1'b1;
        chk("im_addr_0", 32'(im_addr), 32'd0);

        // Sequential fetch from PC_RESET.
        step("seq1", 0, 0, 0, 32'd0);
        chk("seq1_instr", instr_d, 32'h3C01_0001);
        chk("seq1_pcd",   pc_d,    32'h0000_3000);
        chk("seq1_imaddr", 32'(im_addr), 32'd1);
        step("seq2", 0, 0, 0, 32'd0);
        chk("seq2_instr", instr_d, 32'h3421_0002);
        chk("seq2_pc8",   pc8_d,   32'h0000_300C);
        chk("seq2_imaddr", 32'(im_addr), 32'd2);

        // Stall two cycles at 0x3008, with an ignored redirect.
        step("stall1", 1, 0, 0, 32'd0);
        step("stall2", 1, 0, 1, 32'h0000_3100);
        chk("stall_pcf", pc_f, 32'h0000_3008);
        chk("stall_pcd", pc_d, 32'h0000_3004);
        step("unstall", 0, 0, 0, 32'd0);
        chk("unstall_pcf", pc_f, 32'h0000_300C);
        step("to3010", 0, 0, 0, 32'd0);

        // Redirect with delay slot.
        step("redir", 0, 0, 1, 32'h0000_3040);
        chk("dslot_pcd",   pc_d,         32'h0000_3010);
        chk("dslot_valid", 32'(valid_d), 32'd1);
        step("target", 0, 0, 0, 32'd0);
        chk("target_pcd", pc_d, 32'h0000_3040);

        // Flush with and without stall at 0x3020.
        step("to3020", 0, 0, 1, 32'h0000_3020);
        step("flush_stall", 1, 1, 0, 32'd0);
        chk("fs_pcd",   pc_d,         32'h0000_3020);
        chk("fs_valid", 32'(valid_d), 32'd0);
        chk("fs_pcf",   pc_f,         32'h0000_3020);
        step("flush", 0, 1, 0, 32'd0);
        chk("fl_pcf", pc_f, 32'h0000_3024);

        // Fetch errors: misaligned, beyond range, wrap past 2^32.
        step("r3042", 0, 0, 1, 32'h0000_3042);
        step("e3042", 0, 0, 0, 32'd0);
        chk("mis_err", 32'(addr_err_d), 32'd1);
        chk("mis_instr", instr_d, 32'd0);
        step("r7000", 0, 0, 1, 32'h0000_7000);
        step("e7000", 0, 0, 0, 32'd0);
        chk("oor_err", 32'(addr_err_d), 32'd1);
        step("rtop", 0, 0, 1, 32'hFFFF_FFFC);
        step("etop", 0, 0, 0, 32'd0);
        chk("wrap_pcf", pc_f, 32'h0000_0000);
        step("ewrap", 0, 0, 0, 32'd0);
        chk("wrap_err", 32'(addr_err_d), 32'd1);
        chk("wrap_pcd", pc_d, 32'h0000_0000);

        // Last in-range word and first word past the end.
        step("rlast", 0, 0, 1, 32'h0000_6FFC);
        step("elast", 0, 0, 0, 32'd0);
        chk("last_err", 32'(addr_err_d), 32'd0);
        step("epast", 0, 0, 0, 32'd0);
        chk("past_err", 32'(addr_err_d), 32'd1);

        // Asynchronous reset asserted between edges.
        #3;
        reset = 1'b0;
        model_reset();
        #1;
        check_reset_values("async_reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("async_hold");
        @(negedge clk);
        reset = 1'b1;

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            bit          st;
            bit          fl;
            bit          rd;
            logic [31:0] tgt;
            st = ($urandom_range(0, 99) < 20);
            fl = ($urandom_range(0, 99) < 10);
            rd = ($urandom_range(0, 99) < 15);
            case ($urandom_range(0, 9))
                0:       tgt = $urandom;
                1:       tgt = c_im_base + 32'($urandom_range(0, 16383));
                default: tgt = c_im_base + 32'($urandom_range(0, c_im_words - 1)) * 4;
            endcase
            step("rand", st, fl, rd, tgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
